ahb_slot_decoder: RTL and testbench

Parametrised AHB-Lite address decoder with a data-phase response multiplexer and a built-in default slave. It sits between the single AHB-Lite master port and up to `NSLV` slaves. It replaces fixed segment compares with a per-slot base/mask table and registers the data-phase slot selection. Unmapped transfers get a protocol-correct two-cycle ERROR response.

---
 rtl/ahb_slot_decoder_pkg.sv | 27 ++
 rtl/ahb_slot_decoder_if.sv | 32 +++
 rtl/ahb_slot_decoder_default_slave.sv | 104 ++++++++++
 rtl/ahb_slot_decoder.sv | 105 ++++++++++
 tb/tb_ahb_slot_decoder.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_slot_decoder_pkg.sv
// Shared AHB-Lite encodings, widths and the default-slave state type
// for the slot decoder.
package ahb_pkg;

    localparam int AHB_ADDR_W = 36;
    localparam int AHB_DATA_W = 32;
    localparam int AHB_NSLV   = 8;
    localparam int HTRANS_W   = 2;
    localparam int ERR_CNT_W  = 16;

    localparam logic [HTRANS_W-1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [HTRANS_W-1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [HTRANS_W-1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [HTRANS_W-1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_e;

endpackage

// File: rtl/ahb_slot_decoder_if.sv
// AHB-Lite bus bundle between the single master port, the decoder and
// its NSLV slaves; "slave" is the decoder's view, "master" the environment's.
interface ahb_slot_decoder_if
    import ahb_pkg::*;
#(
    parameter int ADDR_W = AHB_ADDR_W,
    parameter int DATA_W = AHB_DATA_W,
    parameter int NSLV   = AHB_NSLV
) ();

    logic [ADDR_W-1:0]      HADDR;
    logic [HTRANS_W-1:0]    HTRANS;
    logic                   HREADY;
    logic [NSLV-1:0]        HSEL;
    logic [NSLV*DATA_W-1:0] HRDATA_S;
    logic [NSLV-1:0]        HREADYOUT_S;
    logic [NSLV-1:0]        HRESP_S;
    logic [DATA_W-1:0]      HRDATA;
    logic                   HREADYOUT;
    logic                   HRESP;

    modport slave (
        input  HADDR, HTRANS, HREADY, HRDATA_S, HREADYOUT_S, HRESP_S,
        output HSEL, HRDATA, HREADYOUT, HRESP
    );

    modport master (
        output HADDR, HTRANS, HREADY, HRDATA_S, HREADYOUT_S, HRESP_S,
        input  HSEL, HRDATA, HREADYOUT, HRESP
    );

endinterface

// File: rtl/ahb_slot_decoder_default_slave.sv
// Default slave: two-cycle ERROR response for active unmapped transfers.
// With AHB_SLOT_DEC_ERRLOG_EN defined it also logs a count and the last address.
module ahb_default_slave
    import ahb_pkg::*;
#(
    parameter int ADDR_W = AHB_ADDR_W
) (
    input  logic HCLK,
    input  logic HRESETn,
    input  logic hready_i,
    input  logic sel_def_i,
    input  logic active_i,
`ifdef AHB_SLOT_DEC_ERRLOG_EN
    input  logic [ADDR_W-1:0]    haddr_i,
    output logic [ERR_CNT_W-1:0] err_cnt_o,
    output logic [ADDR_W-1:0]    err_addr_o,
`endif
    output logic hreadyout_o,
    output logic hresp_o
);

    ds_state_e state_q;
    logic      hreadyout_q;
    logic      hresp_q;
    logic      start;

    assign start = hready_i && sel_def_i && active_i;

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q     <= DS_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
        end else begin
            case (state_q)
                DS_IDLE: begin
                    if (start) begin
                        state_q     <= DS_ERR1;
                        hreadyout_q <= 1'b0;
                        hresp_q     <= HRESP_ERROR;
                    end
                end
                DS_ERR1: begin
                    state_q     <= DS_ERR2;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= HRESP_ERROR;
                end
                DS_ERR2: begin
                    // The edge closing ERR2 is also the next address phase.
                    if (start) begin
                        state_q     <= DS_ERR1;
                        hreadyout_q <= 1'b0;
                        hresp_q     <= HRESP_ERROR;
                    end else begin
                        state_q     <= DS_IDLE;
                        hreadyout_q <= 1'b1;
                        hresp_q     <= HRESP_OKAY;
                    end
                end
                default: begin
                    state_q     <= DS_IDLE;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= HRESP_OKAY;
                end
            endcase
        end
    end

    assign hreadyout_o = hreadyout_q;
    assign hresp_o     = hresp_q;

`ifdef AHB_SLOT_DEC_ERRLOG_EN
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [ADDR_W-1:0]    err_addr_q, err_addr_d;
    logic                 log_en;

    assign log_en = start && (state_q != DS_ERR1);

    always_comb begin
        err_cnt_d  = err_cnt_q;
        err_addr_d = err_addr_q;
        if (log_en) begin
            if (err_cnt_q != ERR_CNT_MAX) begin
                err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            end
            err_addr_d = haddr_i;
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            err_cnt_q  <= '0;
            err_addr_q <= '0;
        end else begin
            err_cnt_q  <= err_cnt_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign err_cnt_o  = err_cnt_q;
    assign err_addr_o = err_addr_q;
`endif

endmodule

// File: rtl/ahb_slot_decoder.sv
// AHB-Lite base/mask slot decoder with registered data-phase response mux
// and built-in default slave; AHB_SLOT_DEC_ERRLOG_EN adds ERR_CNT/ERR_ADDR.
module ahb_slot_decoder
    import ahb_pkg::*;
#(
    parameter int ADDR_W = AHB_ADDR_W,
    parameter int DATA_W = AHB_DATA_W,
    parameter int NSLV   = AHB_NSLV,
    parameter logic [NSLV*ADDR_W-1:0] SLOT_BASE = '0,
    parameter logic [NSLV*ADDR_W-1:0] SLOT_MASK = '0
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    ahb_slot_decoder_if.slave bus
`ifdef AHB_SLOT_DEC_ERRLOG_EN
    ,
    output logic [ERR_CNT_W-1:0] ERR_CNT,
    output logic [ADDR_W-1:0]    ERR_ADDR
`endif
);

    logic [NSLV-1:0]   slot_hit;
    logic [NSLV-1:0]   hsel;
    logic              sel_def;
    logic [NSLV:0]     sel_d;
    logic [NSLV:0]     sel_q;
    logic              active;
    logic              def_ready;
    logic              def_resp;
    logic [DATA_W-1:0] hrdata_mux;
    logic              hready_mux;
    logic              hresp_mux;

    for (genvar i = 0; i < NSLV; i++) begin : g_slot
        localparam logic [ADDR_W-1:0] BASE_I = SLOT_BASE[i*ADDR_W +: ADDR_W];
        localparam logic [ADDR_W-1:0] MASK_I = SLOT_MASK[i*ADDR_W +: ADDR_W];
        assign slot_hit[i] = (MASK_I != '0) &&
                             ((bus.HADDR & MASK_I) == (BASE_I & MASK_I));
    end

    // Lowest index wins on overlap, keeping HSEL one-hot or zero.
    always_comb begin
        logic found;
        hsel  = '0;
        found = 1'b0;
        for (int i = 0; i < NSLV; i++) begin
            if (!found && slot_hit[i]) begin
                hsel[i] = 1'b1;
                found   = 1'b1;
            end
        end
    end

    assign sel_def  = ~|hsel;
    assign sel_d    = {sel_def, hsel};
    assign bus.HSEL = hsel;
    assign active   = (bus.HTRANS == HTRANS_NONSEQ) || (bus.HTRANS == HTRANS_SEQ);

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            sel_q <= {1'b1, {NSLV{1'b0}}};
        end else if (bus.HREADY) begin
            sel_q <= sel_d;
        end
    end

    ahb_default_slave #(
        .ADDR_W (ADDR_W)
    ) u_default_slave (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .hready_i    (bus.HREADY),
        .sel_def_i   (sel_def),
        .active_i    (active),
`ifdef AHB_SLOT_DEC_ERRLOG_EN
        .haddr_i     (bus.HADDR),
        .err_cnt_o   (ERR_CNT),
        .err_addr_o  (ERR_ADDR),
`endif
        .hreadyout_o (def_ready),
        .hresp_o     (def_resp)
    );

    always_comb begin
        hrdata_mux = '0;
        hready_mux = 1'b1;
        hresp_mux  = HRESP_OKAY;
        for (int i = 0; i < NSLV; i++) begin
            if (sel_q[i]) begin
                hrdata_mux = bus.HRDATA_S[i*DATA_W +: DATA_W];
                hready_mux = bus.HREADYOUT_S[i];
                hresp_mux  = bus.HRESP_S[i];
            end
        end
        if (sel_q[NSLV]) begin
            hready_mux = def_ready;
            hresp_mux  = def_resp;
        end
    end

    assign bus.HRDATA    = hrdata_mux;
    assign bus.HREADYOUT = hready_mux;
    assign bus.HRESP     = hresp_mux;

endmodule

// File: tb/tb_ahb_slot_decoder.sv
// Bench for ahb_slot_decoder: decode table, directed protocol sequences and a
// randomized run against a transfer-level model; build with AHB_SLOT_DEC_ERRLOG_EN for the log.
module tb_ahb_slot_decoder;
    import ahb_pkg::*;

    localparam int ADDR_W = 36;
    localparam int DATA_W = 32;
    localparam int NSLV   = 2;
    localparam logic [NSLV*ADDR_W-1:0] BASE = {36'h0_0001_0000, 36'h0_0000_0000};
    localparam logic [NSLV*ADDR_W-1:0] MASK = {36'hF_FC00_0000, 36'hF_FFFF_0000};

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    ahb_slot_decoder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NSLV(NSLV)) bus ();
    assign bus.HREADY = bus.HREADYOUT;

`ifdef AHB_SLOT_DEC_ERRLOG_EN
    logic [ERR_CNT_W-1:0] err_cnt;
    logic [ADDR_W-1:0]    err_addr;
`endif

    ahb_slot_decoder #(
        .ADDR_W (ADDR_W), .DATA_W (DATA_W), .NSLV (NSLV),
        .SLOT_BASE (BASE), .SLOT_MASK (MASK)
    ) dut (
        .HCLK    (clk),
        .HRESETn (rstn),
        .bus     (bus)
`ifdef AHB_SLOT_DEC_ERRLOG_EN
        ,
        .ERR_CNT  (err_cnt),
        .ERR_ADDR (err_addr)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Transfer-level reference: who owns the data phase and how many error cycles remain.
    int          m_own;
    int          m_err;
    int unsigned m_cnt;
    logic [35:0] m_addr;

    function automatic int ref_decode(input logic [35:0] a);
        logic [35:0] b, m;
        for (int i = 0; i < NSLV; i++) begin
            b = BASE[i*ADDR_W +: ADDR_W];
            m = MASK[i*ADDR_W +: ADDR_W];
            if (m != 0 && ((a ^ b) & m) == 0) return i;
        end
        return NSLV;
    endfunction

    function automatic logic exp_ready();
        if (m_own < NSLV) return bus.HREADYOUT_S[m_own];
        return (m_err != 2);
    endfunction

    function automatic logic exp_resp();
        if (m_own < NSLV) return bus.HRESP_S[m_own];
        return (m_err > 0);
    endfunction

    function automatic logic [31:0] exp_rdata();
        if (m_own < NSLV) return bus.HRDATA_S[m_own*DATA_W +: DATA_W];
        return 32'h0;
    endfunction

    task automatic model_reset();
        m_own = NSLV; m_err = 0; m_cnt = 0; m_addr = '0;
    endtask

    task automatic model_edge();
        logic hr;
        int   d;
        if (!rstn) begin
            model_reset();
        end else begin
            hr = exp_ready();
            if (hr) begin
                d     = ref_decode(bus.HADDR);
                m_own = d;
                if (d == NSLV && bus.HTRANS[1]) begin
                    m_err  = 2;
                    if (m_cnt < 65535) m_cnt++;
                    m_addr = bus.HADDR;
                end else begin
                    m_err = 0;
                end
            end else if (m_err == 2) begin
                m_err = 1;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        bus.HTRANS = HTRANS_IDLE;
        bus.HADDR  = '0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    typedef struct {
        logic [35:0] addr;
        logic [1:0]  trans;
        logic [1:0]  hsel;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [35:0] a;
        logic [1:0]  eh;
        int          d, n, guard;
        logic        r;

        vecs[0] = '{36'h0_0000_0100, HTRANS_NONSEQ, 2'b01};
        vecs[1] = '{36'h0_0001_0000, HTRANS_NONSEQ, 2'b10};
        vecs[2] = '{36'h1_0000_0000, HTRANS_NONSEQ, 2'b00};
        vecs[3] = '{36'h0_0000_FFFF, HTRANS_SEQ,    2'b01};
        vecs[4] = '{36'h0_03FF_FFFF, HTRANS_NONSEQ, 2'b10};
        vecs[5] = '{36'h0_0400_0000, HTRANS_NONSEQ, 2'b00};
        vecs[6] = '{36'hF_FFFF_0000, HTRANS_BUSY,   2'b00};
        vecs[7] = '{36'h0_0000_0100, HTRANS_IDLE,   2'b01};

        bus.HADDR       = '0;
        bus.HTRANS      = HTRANS_IDLE;
        bus.HRDATA_S    = {32'hAAAA_AAAA, 32'h5555_5555};
        bus.HREADYOUT_S = 2'b11;
        bus.HRESP_S     = 2'b00;

        do_reset();
        @(negedge clk);
        chk("reset_hreadyout", bus.HREADYOUT, 1'b1);
        chk("reset_hresp", bus.HRESP, 1'b0);
        chk("reset_hrdata", bus.HRDATA, 32'h0);
`ifdef AHB_SLOT_DEC_ERRLOG_EN
        chk("reset_err_cnt", err_cnt, 16'h0);
        chk("reset_err_addr", err_addr, 36'h0);
`endif
        step();

        foreach (vecs[i]) begin
            bus.HADDR  = vecs[i].addr;
            bus.HTRANS = vecs[i].trans;
            @(negedge clk);
            chk($sformatf("decode[%0d]", i), bus.HSEL, vecs[i].hsel);
            step();
        end

        // Read from slot 1 appears one cycle after its address phase.
        do_reset();
        bus.HRDATA_S[DATA_W +: DATA_W] = 32'hDEAD_BEEF;
        bus.HADDR  = 36'h0_0001_0000;
        bus.HTRANS = HTRANS_NONSEQ;
        @(negedge clk);
        chk("rd1_hsel", bus.HSEL, 2'b10);
        chk("rd1_addr_phase_hrdata", bus.HRDATA, 32'h0);
        step();
        bus.HADDR  = 36'h0_0000_0100;
        bus.HTRANS = HTRANS_IDLE;
        @(negedge clk);
        chk("rd1_hrdata", bus.HRDATA, 32'hDEAD_BEEF);
        chk("rd1_hreadyout", bus.HREADYOUT, 1'b1);
        chk("rd1_hresp", bus.HRESP, 1'b0);
        step();

        // Unmapped NONSEQ: ERR1, ERR2, then OKAY.
        bus.HADDR  = 36'h1_0000_0000;
        bus.HTRANS = HTRANS_NONSEQ;
        @(negedge clk);
        chk("unm_hsel", bus.HSEL, 2'b00);
        step();
        bus.HADDR  = 36'h0;
        bus.HTRANS = HTRANS_IDLE;
        @(negedge clk);
        chk("unm_err1_ready", bus.HREADYOUT, 1'b0);
        chk("unm_err1_resp", bus.HRESP, 1'b1);
        chk("unm_err1_rdata", bus.HRDATA, 32'h0);
        step();
        @(negedge clk);
        chk("unm_err2_ready", bus.HREADYOUT, 1'b1);
        chk("unm_err2_resp", bus.HRESP, 1'b1);
        step();
        @(negedge clk);
        chk("unm_done_ready", bus.HREADYOUT, 1'b1);
        chk("unm_done_resp", bus.HRESP, 1'b0);
        step();

        // Slot 0 inserts 3 wait states while HADDR keeps changing.
        bus.HADDR  = 36'h0_0000_0100;
        bus.HTRANS = HTRANS_NONSEQ;
        step();
        bus.HREADYOUT_S[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.HRDATA_S[0 +: DATA_W] = 32'hCAFE_0000 + k;
            bus.HADDR = (k % 2 == 0) ? 36'h0_0001_0000 : 36'h1_0000_0000;
            @(negedge clk);
            chk($sformatf("hold_rdata[%0d]", k), bus.HRDATA, 32'hCAFE_0000 + k);
            chk($sformatf("hold_ready[%0d]", k), bus.HREADYOUT, 1'b0);
            step();
        end
        bus.HREADYOUT_S[0] = 1'b1;
        bus.HRDATA_S[0 +: DATA_W] = 32'h3333_3333;
        @(negedge clk);
        chk("hold_release_rdata", bus.HRDATA, 32'h3333_3333);
        chk("hold_release_ready", bus.HREADYOUT, 1'b1);
        step();
        bus.HTRANS = HTRANS_IDLE;
        @(negedge clk);
        chk("hold_next_rdata", bus.HRDATA, 32'hDEAD_BEEF);
        chk("hold_next_resp", bus.HRESP, 1'b0);
        step();

        // Reset in ERR1 aborts the error response.
        bus.HADDR  = 36'h1_0000_0000;
        bus.HTRANS = HTRANS_NONSEQ;
        step();
        bus.HADDR  = 36'h0;
        bus.HTRANS = HTRANS_IDLE;
        @(negedge clk);
        chk("rst_err1_ready", bus.HREADYOUT, 1'b0);
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_err1_after_ready", bus.HREADYOUT, 1'b1);
        chk("rst_err1_after_resp", bus.HRESP, 1'b0);
        chk("rst_err1_after_rdata", bus.HRDATA, 32'h0);
        step();
        @(negedge clk);
        chk("rst_err1_no_err2", bus.HRESP, 1'b0);
        step();

`ifdef AHB_SLOT_DEC_ERRLOG_EN
        // Three back-to-back unmapped NONSEQ transfers.
        do_reset();
        bus.HADDR  = 36'h2_0000_0000;
        bus.HTRANS = HTRANS_NONSEQ;
        n = 0;
        guard = 0;
        while (n < 3 && guard < 20) begin
            @(negedge clk);
            r = bus.HREADY;
            @(posedge clk);
            if (r) n++;
            guard++;
            #1;
        end
        chk("log_sampled_transfers", n, 3);
        bus.HADDR  = 36'h0;
        bus.HTRANS = HTRANS_IDLE;
        repeat (3) step();
        @(negedge clk);
        chk("log_err_cnt", err_cnt, 16'd3);
        chk("log_err_addr", err_addr, 36'h2_0000_0000);
        step();
`endif

        // Randomized traffic against the reference model.
        do_reset();
        model_reset();
        for (int c = 0; c < 600; c++) begin
            rstn = ($urandom_range(0, 49) != 0);
            case ($urandom_range(0, 4))
                0: a = {20'h0, 16'($urandom)};
                1: a = {10'h0, 26'($urandom)};
                2: a = 36'h1_0000_0000 | 36'($urandom);
                3: a = {4'($urandom), 32'($urandom)};
                default: a = 36'h2_0000_0000;
            endcase
            bus.HADDR       = a;
            bus.HTRANS      = 2'($urandom);
            bus.HRDATA_S    = {32'($urandom), 32'($urandom)};
            bus.HREADYOUT_S = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
            bus.HRESP_S     = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
            d  = ref_decode(a);
            eh = 2'b00;
            if (d < NSLV) eh[d] = 1'b1;
            @(negedge clk);
            chk($sformatf("rnd_hsel[%0d]", c), bus.HSEL, eh);
            chk($sformatf("rnd_hrdata[%0d]", c), bus.HRDATA, exp_rdata());
            chk($sformatf("rnd_hreadyout[%0d]", c), bus.HREADYOUT, exp_ready());
            chk($sformatf("rnd_hresp[%0d]", c), bus.HRESP, exp_resp());
`ifdef AHB_SLOT_DEC_ERRLOG_EN
            chk($sformatf("rnd_err_cnt[%0d]", c), err_cnt, m_cnt[15:0]);
            chk($sformatf("rnd_err_addr[%0d]", c), err_addr, m_addr);
`endif
            @(posedge clk);
            model_edge();
            #1;
        end
        rstn = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
